// File: rtl/apb_frame_master_pkg.sv
// Shared definitions for the RX-frame-to-APB master: command codes, response codes,
// frame layout and FSM state encoding.
package apb_frame_master_pkg;

  localparam int FRAME_W = 56;
  localparam int RSP_W   = 40;

  typedef enum logic [2:0] {
    CMD_WREQ = 3'd2,
    CMD_RREQ = 3'd3,
    CMD_RRES = 3'd4
  } cmd_e;

  localparam logic [7:0] RSP_OK  = 8'h04;
  localparam logic [7:0] RSP_ERR = 8'h84;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [31:0] wdata;
  } frame_t;

  // Only the low three command bits select the operation.
  function automatic logic is_req(input logic [2:0] code);
    return (code == CMD_WREQ) || (code == CMD_RREQ);
  endfunction

endpackage

// File: rtl/apb_frame_master_if.sv
// APB3 bus bundle between the frame master and its slave.
interface apb_frame_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired marks the last wait cycle allowed before abort.
module apb_wait_timer #(
  parameter int TO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(TO_CYC - 1);

  logic [7:0] cnt;

  // NOTE: non-blocking assignments so every register updates from pre-edge values;
  // rst is synchronous, so it is simply the highest-priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Counter holds the number of waits already seen, so cnt == TO_CYC-1 is the TO_CYC-th.
  assign expired = (cnt >= LAST);

endmodule

// File: rtl/apb_frame_master.sv
// Runs one APB3 transfer per accepted command frame; read requests produce a 5-byte
// response frame that is held until the TX side accepts it.
module apb_frame_master
  import apb_frame_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_vld,
  output logic               busy,
  apb_frame_master_if.master apb,
  output logic [RSP_W-1:0]   rsp_data,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic               ovr_err,
  output logic               cmd_err,
  output logic               to_err
);

  state_e            state;
  frame_t            frm;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              accept;
  logic              wait_en;
  logic              tmr_expired;
  logic              unused_cmd_hi;

  assign frm           = frame_t'(frame_data);
  assign req_addr      = frm.addr;
  assign req_wdata     = frm.wdata;
  assign unused_cmd_hi = ^frm.cmd[7:3];

  assign accept  = (state == S_IDLE) && frame_vld && is_req(frm.cmd[2:0]);
  assign wait_en = (state == S_ACCESS) && !apb.pready;
  assign busy    = (state != S_IDLE);

  apb_wait_timer #(.TO_CYC(TO_CYC)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (wait_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      rsp_data    <= '0;
      rsp_vld     <= 1'b0;
      ovr_err     <= 1'b0;
      cmd_err     <= 1'b0;
      to_err      <= 1'b0;
    end else begin
      // Any frame arriving outside IDLE is dropped, including the RESP exit cycle.
      ovr_err <= frame_vld && (state != S_IDLE);
      cmd_err <= 1'b0;
      to_err  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            apb.paddr  <= req_addr;
            apb.pwdata <= req_wdata;
            apb.pwrite <= (frm.cmd[2:0] == CMD_WREQ);
            apb.psel   <= 1'b1;
            state      <= S_SETUP;
          end else if (frame_vld) begin
            cmd_err <= 1'b1;
          end
        end

        S_SETUP: begin
          apb.penable <= 1'b1;
          state       <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready takes priority over expiry on the last permitted wait cycle.
          if (apb.pready || tmr_expired) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            to_err      <= !apb.pready;
            if (apb.pwrite) begin
              state <= S_IDLE;
            end else begin
              rsp_vld  <= 1'b1;
              rsp_data <= (apb.pready && !apb.pslverr) ? {RSP_OK, apb.prdata}
                                                       : {RSP_ERR, {DATA_W{1'b0}}};
              state    <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_frame_master.sv
// Randomized bench for apb_frame_master: acts as APB slave and response sink, and predicts
// each transfer's timing and response from the command, wait count and error choice.
module tb_apb_frame_master;

  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] frame_data;
  logic        frame_vld;
  logic        busy;
  logic [39:0] rsp_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic        ovr_err;
  logic        cmd_err;
  logic        to_err;

  int vectors     = 0;
  int miscompares = 0;
  bit ovr_exp     = 1'b0;

  apb_frame_master_if #(.ADDR_W(16), .DATA_W(32)) apb ();

  apb_frame_master #(.ADDR_W(16), .DATA_W(32), .TO_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_data (frame_data),
    .frame_vld  (frame_vld),
    .busy       (busy),
    .apb        (apb),
    .rsp_data   (rsp_data),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .ovr_err    (ovr_err),
    .cmd_err    (cmd_err),
    .to_err     (to_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next negedge, where outputs are sampled and inputs are changed.
  task automatic tick();
    @(negedge clk);
    check("ovr_err", {63'd0, ovr_err}, {63'd0, ovr_exp});
    ovr_exp   = 1'b0;
    frame_vld = 1'b0;
  endtask

  // Throw a write frame at the busy master; it must be dropped and flagged.
  task automatic inject();
    frame_data = {8'h02, 16'($urandom), 32'($urandom)};
    frame_vld  = 1'b1;
    ovr_exp    = 1'b1;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] wdata,
                         input int waits, input bit slverr, input logic [31:0] rdata,
                         input int hold, input int ovr_acc, input int ovr_rsp);
    bit          valid;
    bit          is_wr;
    bit          timeout;
    int          n_acc;
    logic [39:0] exp_rsp;

    valid   = (cmd[2:0] == 3'd2) || (cmd[2:0] == 3'd3);
    is_wr   = (cmd[2:0] == 3'd2);
    timeout = (waits >= TO_CYC);
    n_acc   = timeout ? TO_CYC : waits + 1;
    exp_rsp = (timeout || slverr) ? {8'h84, 32'h0} : {8'h04, rdata};

    frame_data = {cmd, addr, wdata};
    frame_vld  = 1'b1;
    tick();
    frame_data = {$urandom, $urandom};

    if (!valid) begin
      check("cmd_err", {63'd0, cmd_err}, 64'd1);
      check("bad_psel", {63'd0, apb.psel}, 64'd0);
      check("bad_busy", {63'd0, busy}, 64'd0);
      tick();
      check("cmd_err_1cyc", {63'd0, cmd_err}, 64'd0);
      check("bad_psel2", {63'd0, apb.psel}, 64'd0);
      return;
    end

    check("setup_psel", {63'd0, apb.psel}, 64'd1);
    check("setup_penable", {63'd0, apb.penable}, 64'd0);
    check("setup_paddr", {48'd0, apb.paddr}, {48'd0, addr});
    check("setup_pwrite", {63'd0, apb.pwrite}, {63'd0, is_wr});
    if (is_wr) check("setup_pwdata", {32'd0, apb.pwdata}, {32'd0, wdata});
    check("setup_busy", {63'd0, busy}, 64'd1);
    check("setup_cmd_err", {63'd0, cmd_err}, 64'd0);
    tick();

    for (int k = 0; k < n_acc; k++) begin
      check("acc_psel", {63'd0, apb.psel}, 64'd1);
      check("acc_penable", {63'd0, apb.penable}, 64'd1);
      check("acc_paddr", {48'd0, apb.paddr}, {48'd0, addr});
      check("acc_to_err", {63'd0, to_err}, 64'd0);
      apb.pready  = (k == waits);
      apb.pslverr = (k == waits) && slverr;
      apb.prdata  = (k == waits) ? rdata : 32'($urandom);
      if (k == ovr_acc) inject();
      tick();
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
    end

    check("done_psel", {63'd0, apb.psel}, 64'd0);
    check("done_penable", {63'd0, apb.penable}, 64'd0);
    check("to_err", {63'd0, to_err}, {63'd0, timeout});

    if (is_wr) begin
      check("wr_rsp_vld", {63'd0, rsp_vld}, 64'd0);
      check("wr_busy", {63'd0, busy}, 64'd0);
      check("idle_paddr", {48'd0, apb.paddr}, {48'd0, addr});
    end else begin
      for (int h = 0; h <= hold; h++) begin
        check("rsp_vld", {63'd0, rsp_vld}, 64'd1);
        check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp});
        check("rsp_busy", {63'd0, busy}, 64'd1);
        check("rsp_psel", {63'd0, apb.psel}, 64'd0);
        if (h > 0) check("rsp_to_err", {63'd0, to_err}, 64'd0);
        rsp_rdy = (h == hold);
        if (h == ovr_rsp) inject();
        tick();
      end
      rsp_rdy = 1'b0;
      check("rsp_drop", {63'd0, rsp_vld}, 64'd0);
      check("rsp_idle_busy", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int         waits;

    rst         = 1'b1;
    frame_data  = '0;
    frame_vld   = 1'b0;
    rsp_rdy     = 1'b0;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_psel", {63'd0, apb.psel}, 64'd0);
    check("rst_penable", {63'd0, apb.penable}, 64'd0);
    check("rst_pwrite", {63'd0, apb.pwrite}, 64'd0);
    check("rst_paddr", {48'd0, apb.paddr}, 64'd0);
    check("rst_pwdata", {32'd0, apb.pwdata}, 64'd0);
    check("rst_rsp", {23'd0, rsp_vld, rsp_data}, 64'd0);
    check("rst_errs", {61'd0, ovr_err, cmd_err, to_err}, 64'd0);
    rst = 1'b0;
    tick();

    run_txn(8'h02, 16'h1234, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0, -1, -1);
    run_txn(8'h03, 16'h00A0, 32'h55AA55AA, 3, 1'b0, 32'hCAFEF00D, 4, -1, -1);
    run_txn(8'h03, 16'h0BAD, 32'h0, 1, 1'b1, 32'h12345678, 0, -1, -1);
    run_txn(8'h03, 16'h0F00, 32'h0, 50, 1'b0, 32'h0, 2, -1, -1);
    run_txn(8'h03, 16'h0077, 32'h0, TO_CYC - 1, 1'b0, 32'h77777777, 1, -1, -1);
    run_txn(8'h03, 16'h0088, 32'h0, TO_CYC, 1'b0, 32'h88888888, 1, -1, -1);
    run_txn(8'h02, 16'hFFFF, 32'h1, 2, 1'b1, 32'h0, 0, -1, -1);
    run_txn(8'h02, 16'h2222, 32'h2, 20, 1'b0, 32'h0, 0, -1, -1);
    run_txn(8'h04, 16'h4444, 32'h4, 0, 1'b0, 32'h0, 0, -1, -1);
    run_txn(8'h07, 16'h7777, 32'h7, 0, 1'b0, 32'h0, 0, -1, -1);
    run_txn(8'h02, 16'h3000, 32'hA5A5A5A5, 2, 1'b0, 32'h0, 0, 1, -1);
    run_txn(8'h03, 16'h3004, 32'h0, 0, 1'b0, 32'hBEEFCAFE, 3, -1, 2);
    run_txn(8'h03, 16'h3008, 32'h0, 1, 1'b0, 32'h0BADF00D, 2, -1, 2);

    // Reset during ACCESS: bus drops at that edge with no error pulse.
    frame_data = {8'h03, 16'h5555, 32'h0};
    frame_vld  = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_psel", {63'd0, apb.psel}, 64'd0);
    check("mid_rst_penable", {63'd0, apb.penable}, 64'd0);
    check("mid_rst_rsp_vld", {63'd0, rsp_vld}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_errs", {62'd0, cmd_err, to_err}, 64'd0);
    rst = 1'b0;
    run_txn(8'h03, 16'h5556, 32'h0, 2, 1'b0, 32'h600DDA7A, 1, -1, -1);

    for (int i = 0; i < 150; i++) begin
      c = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        if (c[2:0] == 3'd2 || c[2:0] == 3'd3) c[2] = 1'b1;
      end else begin
        c[2:0] = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
      end
      waits = $urandom_range(0, 10);
      run_txn(c, 16'($urandom), 32'($urandom), waits, ($urandom_range(0, 3) == 0),
              32'($urandom), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
